// File: rtl/vga_sync_decoder.sv
// Recovers pixel/line coordinates from a VGA hs/vs/blank stream sampled on
// pixel_clk rising edges, and tracks whether that stream has a consistent timing.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_clk,
  input  logic       hs,
  input  logic       vs,
  input  logic       blank,
  output logic [9:0] RxX,
  output logic [9:0] RxY,
  output logic       rx_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic       err_h,
  output logic       err_v,
  output logic       err_blank
);

  localparam logic [9:0] H_LOAD = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] V_LOAD = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t     state;
  logic       pclk_q, hs_q, vs_q;
  logic [9:0] h_cnt, v_cnt;
  logic       err_h_c, err_v_c, err_blank_c;

  logic       tick, hs_fall, vs_fall, h_wrap, h_mis, v_mis, mis, vis_next;
  logic [9:0] h_next, v_next;

  always_comb begin
    tick    = ~pclk_q & pixel_clk;
    hs_fall = tick & hs_q & ~hs;
    vs_fall = tick & vs_q & ~vs;
    h_wrap  = (h_cnt == H_LAST);
    h_mis   = hs_fall & (h_cnt != H_LOAD - 10'd1);
    // vs must fall exactly where the free-running count would enter line V_LOAD
    v_mis   = vs_fall & ~(h_wrap & (v_cnt == V_LOAD - 10'd1));
    mis     = h_mis | v_mis;
    h_next  = hs_fall ? H_LOAD : (h_wrap ? '0 : h_cnt + 10'd1);
    if (vs_fall)     v_next = V_LOAD;
    else if (h_wrap) v_next = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    else             v_next = v_cnt;
    vis_next = (h_next < H_VIS) && (v_next < V_VIS);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pclk_q      <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      state       <= SEARCH;
      err_h_c     <= 1'b0;
      err_v_c     <= 1'b0;
      err_blank_c <= 1'b0;
    end else begin
      pclk_q <= pixel_clk;
      if (tick) begin
        hs_q  <= hs;
        vs_q  <= vs;
        h_cnt <= h_next;
        v_cnt <= v_next;
        if (state != SEARCH) begin
          if (h_mis) err_h_c <= 1'b1;
          if (v_mis) err_v_c <= 1'b1;
        end
        if (state == LOCKED && blank != vis_next) err_blank_c <= 1'b1;
        case (state)
          SEARCH:  if (vs_fall) state <= ALIGN;
          ALIGN:   if (mis) state <= SEARCH;
                   else if (vs_fall) state <= LOCKED;
          LOCKED:  if (mis) state <= SEARCH;
          default: state <= SEARCH;
        endcase
      end
    end
  end

  // Output stage trails the tick-domain state by one Clk.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      RxX         <= '0;
      RxY         <= '0;
      rx_valid    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      err_blank   <= 1'b0;
    end else begin
      RxX         <= h_cnt;
      RxY         <= v_cnt;
      locked      <= (state == LOCKED);
      rx_valid    <= (state == LOCKED) && (h_cnt < H_VIS) && (v_cnt < V_VIS);
      line_start  <= (state == LOCKED) && (h_cnt == '0) && (RxX != '0);
      frame_start <= (state == LOCKED) && (h_cnt == '0) && (v_cnt == '0) && (RxX != '0);
      err_h       <= err_h_c;
      err_v       <= err_v_c;
      err_blank   <= err_blank_c;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Drives a scaled VGA timing into vga_sync_decoder and compares every pixel
// against coordinates and lock/error expectations derived from the generator.
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 4, HSW = 4, HT = 28;
  localparam int VA = 12, VF = 2, VSW = 2, VT = 18;
  localparam int FRAME = HT * VT;

  logic       Clk = 1'b0, Reset = 1'b0, pixel_clk = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [9:0] RxX, RxY;
  logic       rx_valid, line_start, frame_start, locked, err_h, err_v, err_blank;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_TOTAL(VT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pixel_clk(pixel_clk),
    .hs(hs), .vs(vs), .blank(blank),
    .RxX(RxX), .RxY(RxY), .rx_valid(rx_valid),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .err_h(err_h), .err_v(err_v), .err_blank(err_blank)
  );

  always #10 Clk = ~Clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Generator position and expectation model
  int gx = HT - 1, gy = VT - 1;
  int clean_vs = 0;
  int shift_line = -1;
  int blank_x = -1, blank_y = -1;
  bit exp_err_h = 0, exp_err_v = 0, exp_err_blank = 0;

  task automatic step();
    bit lk;
    int hs_start;
    @(negedge Clk) pixel_clk = 1'b0;
    @(negedge Clk);
    lk = (clean_vs >= 2);
    check("locked",      int'(locked),      int'(lk));
    check("err_h",       int'(err_h),       int'(exp_err_h));
    check("err_v",       int'(err_v),       int'(exp_err_v));
    check("err_blank",   int'(err_blank),   int'(exp_err_blank));
    check("line_start",  int'(line_start),  int'(lk && gx == 0));
    check("frame_start", int'(frame_start), int'(lk && gx == 0 && gy == 0));
    check("rx_valid",    int'(rx_valid),    int'(lk && gx < HA && gy < VA));
    if (lk) begin
      check("RxX", int'(RxX), gx);
      check("RxY", int'(RxY), gy);
    end
    gx = gx + 1;
    if (gx == HT) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end
    hs_start = (gy == shift_line) ? HA + HF - 4 : HA + HF;
    hs    = !(gx >= hs_start && gx < HA + HF + HSW);
    vs    = !(gy >= VA + VF && gy < VA + VF + VSW);
    blank = (gx < HA && gy < VA) || (gx == blank_x && gy == blank_y);
    if (gx == 0 && gy == VA + VF) clean_vs++;
    if (gy == shift_line && gx == hs_start) begin
      clean_vs  = 0;
      exp_err_h = 1;
    end
    pixel_clk = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check("rst_RxX",         int'(RxX),         0);
    check("rst_RxY",         int'(RxY),         0);
    check("rst_rx_valid",    int'(rx_valid),    0);
    check("rst_line_start",  int'(line_start),  0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_locked",      int'(locked),      0);
    check("rst_err_h",       int'(err_h),       0);
    check("rst_err_v",       int'(err_v),       0);
    check("rst_err_blank",   int'(err_blank),   0);
  endtask

  // Counts Clk cycles with each pulse high
  int ls_cnt = 0, fs_cnt = 0;
  logic [9:0] fs_x = '1, fs_y = '1;
  logic fs_ls = 1'b0;
  always @(negedge Clk) begin
    if (line_start) ls_cnt++;
    if (frame_start) begin
      fs_cnt++;
      fs_x  = RxX;
      fs_y  = RxY;
      fs_ls = line_start;
    end
  end

  initial begin
    int sl, bx, by, rx, ry, skip;

    repeat (3) @(negedge Clk);
    check_reset_outputs();
    #2 Reset = 1'b1;

    // Clean timing for three frames; lock expected at the second vs fall
    repeat (3 * FRAME) step();
    check("locked_after_3_frames", int'(locked), 1);

    // Pulse count over one full frame
    do step(); while (!(gx == 1 && gy == 0));
    #1 ls_cnt = 0; fs_cnt = 0;
    repeat (FRAME) step();
    #1;
    check("line_start_count",  ls_cnt, VT);
    check("frame_start_count", fs_cnt, 1);
    check("frame_start_at_origin", int'({fs_x, fs_y, fs_ls}), 1);

    // pixel_clk stalled for 100 Clk at a random position
    skip = $urandom_range(1, FRAME - 1);
    repeat (skip) step();
    @(negedge Clk) pixel_clk = 1'b0;
    repeat (100) @(negedge Clk);
    check("stall_RxX",    int'(RxX),    gx);
    check("stall_RxY",    int'(RxY),    gy);
    check("stall_locked", int'(locked), 1);
    check("stall_errs",   int'({err_h, err_v, err_blank}), 0);

    // blank asserted at a position that must be blanked
    bx = $urandom_range(HA, HT - 1);
    by = $urandom_range(0, VT - 1);
    blank_x = bx;
    blank_y = by;
    do step(); while (!(gx == bx && gy == by));
    exp_err_blank = 1;
    blank_x = -1;
    blank_y = -1;
    step();
    check("err_blank_set",        int'(err_blank), 1);
    check("locked_after_blank",   int'(locked),    1);

    // One hs falling edge 4 pixels early
    sl = $urandom_range(1, VA - 1);
    do step(); while (!(gx == 0 && gy == sl));
    shift_line = sl;
    do step(); while (gx != HA + HF - 4);
    step();
    check("err_h_set",   int'(err_h),  1);
    check("locked_drop", int'(locked), 0);
    do step(); while (gy != sl + 1);
    shift_line = -1;
    for (int i = 0; i < 3 * FRAME && clean_vs < 2; i++) step();
    repeat (HT * 2) step();
    check("relock_after_hs", int'(locked), 1);
    check("err_h_sticky",    int'(err_h),  1);

    // Reset asserted mid-line
    rx = $urandom_range(1, HA - 4);
    ry = $urandom_range(0, VA - 1);
    do step(); while (!(gx == rx && gy == ry));
    #3 Reset = 1'b0;
    #1 check_reset_outputs();
    clean_vs      = 0;
    exp_err_h     = 0;
    exp_err_v     = 0;
    exp_err_blank = 0;
    step();
    step();
    #2 Reset = 1'b1;
    for (int i = 0; i < 3 * FRAME && clean_vs < 2; i++) step();
    repeat (HT * 2) step();
    check("relock_after_reset", int'(locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, default 640, visible pixels per line; H_FRONT, default 16, front porch pixels; H_TOTAL, default 800, pixels per line; V_ACTIVE, default 480, visible lines; V_FRONT, default 10, front porch lines; V_TOTAL, default 525, lines per frame.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning), clock and reset first:
- Clk  in  1  system clock; 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- pixel_clk  in  1  pixel clock from the VGA controller; synchronous to Clk at Clk/2; used only as a data signal.
- hs  in  1  horizontal sync; active low.
- vs  in  1  vertical sync; active low.
- blank  in  1  blanking; active low (1 = visible).
- RxX  out  10  recovered horizontal pixel coordinate.
- RxY  out  10  recovered vertical line coordinate.
- rx_valid  out  1  RxX/RxY identify a visible pixel while locked.
- line_start  out  1  one-Clk pulse when RxX wraps to 0.
- frame_start  out  1  one-Clk pulse when RxX and RxY both wrap to 0.
- locked  out  1  the decoder is tracking a consistent timing.
- err_h  out  1  sticky flag; hs edge at an unexpected position.
- err_v  out  1  sticky flag; vs edge at an unexpected position.
- err_blank  out  1  sticky flag; blank disagrees with the recovered position.

Function
REQ-003 Pixel tick SHALL be defined as: a Clk edge where registered pixel_clk was 0 and current pixel_clk is 1. All counters and sync sampling advance only on pixel ticks.
REQ-004 hs, vs and blank SHALL be sampled on pixel ticks only. Falling-edge detect compares each sample with the previous tick's sample.
REQ-005 h_cnt SHALL behave as follows on each tick: increment by 1; wrap from H_TOTAL-1 to 0; on wrap, v_cnt increments and wraps from V_TOTAL-1 to 0.
REQ-006 On an hs falling edge, h_cnt SHALL be loaded with H_ACTIVE+H_FRONT (656), overriding the increment on that tick.
REQ-007 On a vs falling edge, v_cnt SHALL be loaded with V_ACTIVE+V_FRONT (490), overriding the increment on that tick.
REQ-008 The FSM SHALL have states SEARCH, ALIGN and LOCKED.
- SEARCH->ALIGN on the first vs falling edge.
- ALIGN->LOCKED on the next vs falling edge, provided no hs or vs mismatch occurred since entering ALIGN.
- ALIGN->SEARCH on any mismatch.
- LOCKED->SEARCH on any mismatch.
REQ-009 A mismatch SHALL be either of the following:
- an hs falling edge where the free-running h_cnt value before loading is not 655 (the value one below the load target);
- a vs falling edge at h_cnt position other than the one where v_cnt would have been 489.
REQ-010 Mismatches SHALL be ignored in SEARCH for state transitions; counters still resync in every state.
REQ-011 err_h SHALL be set on an hs mismatch in LOCKED or ALIGN, and err_v SHALL be set on a vs mismatch in LOCKED or ALIGN. Both hold until reset.
REQ-012 err_blank SHALL be set in LOCKED when the sampled blank differs from (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE). It holds until reset.
REQ-013 Simultaneous hs and vs falling edges on one tick SHALL apply both loads and both checks in that tick.
REQ-014 locked SHALL be 1 exactly while the FSM is in LOCKED, registered, and SHALL drop on the Clk edge following the mismatching tick.
REQ-015 RxX and RxY SHALL equal h_cnt and v_cnt, registered, with one Clk of latency after the tick.
REQ-016 rx_valid SHALL equal locked && RxX<H_ACTIVE && RxY<V_ACTIVE.
REQ-017 line_start SHALL be asserted for exactly one Clk when RxX becomes 0, and only while locked.
REQ-018 frame_start SHALL be asserted for exactly one Clk when RxX and RxY become 0, and only while locked. It coincides with a line_start.
REQ-019 pixel_clk stopped SHALL cause counters and outputs to hold, with no state change.

Reset
REQ-020 While Reset=0, asynchronously:
- h_cnt, v_cnt, RxX and RxY SHALL be 0;
- the FSM SHALL be in SEARCH;
- locked, rx_valid, line_start, frame_start, err_h, err_v and err_blank SHALL be 0;
- edge-detect history SHALL be 1 (syncs idle).
REQ-021 On release, decoding SHALL begin at the first pixel tick. Reset mid-frame needs two vs falling edges to relock.

Verification
REQ-022 The bench SHALL apply a clean 640x480 timing from a reference generator for 3 frames, with the following required response:
- locked=1 after the second vs falling edge;
- RxX/RxY equal the generator DrawX/DrawY each pixel thereafter;
- all err flags 0.
REQ-023 The bench SHALL, while locked, shift one hs falling edge 4 pixels early, with the following required response:
- err_h=1 and locked=0 one Clk later;
- relock after two further clean vs falling edges;
- err_h stays 1.
REQ-024 The bench SHALL, while locked, drive blank=1 at RxX=700, with the following required response: err_blank=1; locked unchanged.
REQ-025 The bench SHALL, while locked, count pulses over one full frame, with the following required response:
- 525 line_start pulses;
- exactly 1 frame_start, coincident with RxX=0, RxY=0.
REQ-026 The bench SHALL assert Reset=0 mid-line at RxX=300, with the following required response:
- all outputs 0 immediately, without waiting for a Clk edge;
- locked returns only after two vs falling edges.
REQ-027 The bench SHALL hold pixel_clk at 0 for 100 Clk while locked, with the following required response: RxX/RxY frozen; locked stays 1; no err flags.
